// File: rtl/ddr_launch_ctrl_pkg.sv
// ddr_launch_ctrl_pkg
// Purpose: shared definitions for the DDR-domain CGRA launch controller.
//   - state_e: launch FSM state encodings (3-bit)
//   - DEF_*  : default parameter values for the filter length and run timeout
package ddr_launch_ctrl_pkg;

  localparam int unsigned DEF_FILTER_LEN = 2;
  localparam int unsigned DEF_TIMEOUT_W  = 16;
  localparam int unsigned DEF_TIMEOUT    = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILTER = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

endpackage

// File: rtl/ddr_launch_ctrl_req_glitch_filter.sv
// ddr_launch_ctrl_req_glitch_filter
// Purpose: counts consecutive high request samples while the launch FSM is
// filtering, and flags when the required run length has been reached.
// Ports:
//   clk    in  clock (posedge)
//   rst    in  synchronous active-high reset
//   load   in  restart the count at 1 (first high sample already seen)
//   inc    in  count one more high sample (saturates at FILTER_LEN)
//   full_c out count == FILTER_LEN (combinational from the count register)
module ddr_launch_ctrl_req_glitch_filter
  import ddr_launch_ctrl_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic full_c
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [CNT_W-1:0] cnt;

  // Consecutive-high sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(1);
    end else if (inc && !full_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign full_c = (cnt == CNT_W'(FILTER_LEN));

endmodule

// File: rtl/ddr_launch_ctrl.sv
// ddr_launch_ctrl
// Purpose: glitch-filters the synchronized CPU request, fires a one-cycle
// CGRA start pulse, times the run until done or timeout, and returns a
// 4-phase acknowledge level to the CPU side.
// Ports:
//   clk_ddr     in  DDR-domain clock (posedge)
//   rst_ddr     in  synchronous active-high reset
//   req_sync    in  synchronized 4-phase request level
//   cgra_done   in  CGRA completion, only honoured in RUN
//   cgra_start  out one-cycle launch pulse
//   busy        out high in LAUNCH and RUN
//   done_ack    out 4-phase acknowledge level
//   timeout_err out last run was ended by timeout
//   run_cycles  out RUN cycles spent by the last run
module ddr_launch_ctrl
  import ddr_launch_ctrl_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
  parameter int unsigned TIMEOUT_W  = DEF_TIMEOUT_W,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                 clk_ddr,
  input  logic                 rst_ddr,
  input  logic                 req_sync,
  input  logic                 cgra_done,
  output logic                 cgra_start,
  output logic                 busy,
  output logic                 done_ack,
  output logic                 timeout_err,
  output logic [TIMEOUT_W-1:0] run_cycles
);

  state_e               state, state_nxt;
  logic                 armed, armed_nxt;
  logic [TIMEOUT_W-1:0] run_cnt, run_cnt_nxt;
  logic [TIMEOUT_W-1:0] run_cycles_nxt;
  logic                 timeout_err_nxt;
  logic                 start_nxt, busy_nxt, ack_nxt;
  logic                 filt_load, filt_inc, filt_full;

  ddr_launch_ctrl_req_glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk    (clk_ddr),
    .rst    (rst_ddr),
    .load   (filt_load),
    .inc    (filt_inc),
    .full_c (filt_full)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk_ddr) begin
    if (rst_ddr) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      run_cnt     <= '0;
      cgra_start  <= 1'b0;
      busy        <= 1'b0;
      done_ack    <= 1'b0;
      timeout_err <= 1'b0;
      run_cycles  <= '0;
    end else begin
      state       <= state_nxt;
      armed       <= armed_nxt;
      run_cnt     <= run_cnt_nxt;
      cgra_start  <= start_nxt;
      busy        <= busy_nxt;
      done_ack    <= ack_nxt;
      timeout_err <= timeout_err_nxt;
      run_cycles  <= run_cycles_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    armed_nxt       = armed;
    run_cnt_nxt     = run_cnt;
    run_cycles_nxt  = run_cycles;
    timeout_err_nxt = timeout_err;
    filt_load       = 1'b0;
    filt_inc        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A request still high from before reset/ack cannot launch until seen low
        if (!req_sync) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          state_nxt = ST_FILTER;
          armed_nxt = 1'b0;
          filt_load = 1'b1;
        end
      end
      ST_FILTER: begin
        if (!req_sync) begin
          state_nxt = ST_IDLE;
        end else if (filt_full) begin
          state_nxt       = ST_LAUNCH;
          run_cycles_nxt  = '0;
          timeout_err_nxt = 1'b0;
        end else begin
          filt_inc = 1'b1;
        end
      end
      ST_LAUNCH: begin
        state_nxt   = ST_RUN;
        run_cnt_nxt = TIMEOUT_W'(1);
      end
      ST_RUN: begin
        // Done takes priority over a coincident timeout
        if (cgra_done) begin
          state_nxt       = ST_ACK;
          run_cycles_nxt  = run_cnt;
          timeout_err_nxt = 1'b0;
        end else if (run_cnt == TIMEOUT_W'(TIMEOUT)) begin
          state_nxt       = ST_ACK;
          run_cycles_nxt  = run_cnt;
          timeout_err_nxt = 1'b1;
        end else begin
          run_cnt_nxt = run_cnt + TIMEOUT_W'(1);
        end
      end
      ST_ACK: begin
        if (!req_sync) begin
          state_nxt = ST_IDLE;
          armed_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the state being entered
    start_nxt = (state_nxt == ST_LAUNCH);
    busy_nxt  = (state_nxt == ST_LAUNCH) || (state_nxt == ST_RUN);
    ack_nxt   = (state_nxt == ST_ACK);
  end

endmodule

// File: tb/tb_ddr_launch_ctrl.sv
// tb_ddr_launch_ctrl
// Purpose: directed self-checking bench for ddr_launch_ctrl with
// FILTER_LEN=2, TIMEOUT_W=16, TIMEOUT=8.
module tb_ddr_launch_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        done;
  logic        start;
  logic        busy;
  logic        ack;
  logic        err;
  logic [15:0] rc;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        req;
    logic        done;
    logic        start;
    logic        busy;
    logic        ack;
    logic        err;
    logic [15:0] rc;
  } vec_t;

  vec_t vecs[$];

  ddr_launch_ctrl #(
    .FILTER_LEN (2),
    .TIMEOUT_W  (16),
    .TIMEOUT    (8)
  ) dut (
    .clk_ddr     (clk),
    .rst_ddr     (rst),
    .req_sync    (req),
    .cgra_done   (done),
    .cgra_start  (start),
    .busy        (busy),
    .done_ack    (ack),
    .timeout_err (err),
    .run_cycles  (rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic q, input logic d,
                              input logic s, input logic b, input logic a,
                              input logic e, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.req = q; v.done = d;
    v.start = s; v.busy = b; v.ack = a; v.err = e; v.rc = c;
    return v;
  endfunction

  // Drive inputs, take one clock edge, then settle past it
  task automatic step(input logic r, input logic q, input logic d);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic s, input logic b,
                            input logic a, input logic e, input logic [15:0] c);
    checks++;
    if ({start, busy, ack, err, rc} !== {s, b, a, e, c}) begin
      errors++;
      $display("FAIL %s: got start=%0b busy=%0b ack=%0b err=%0b run_cycles=%0d, want start=%0b busy=%0b ack=%0b err=%0b run_cycles=%0d",
               name, start, busy, ack, err, rc, s, b, a, e, c);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 1'b1;
    done   = 1'b0;

    //              rst   req   done  start busy  ack   err   run_cycles
    // Reset with a stale high request, then arm and launch
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0));
    // RUN cycles 1..5, done on the 5th
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5));
    // Ack held while request high, released the cycle after it drops
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5));
    // One-cycle glitch is rejected; stray done in IDLE is ignored
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      expect_out($sformatf("vec%0d", i), vecs[i].start, vecs[i].busy,
                 vecs[i].ack, vecs[i].err, vecs[i].rc);
    end

    // Timeout after 8 RUN cycles; done during LAUNCH and req drop in RUN ignored
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    expect_out("to_launch_clears", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b1);
    expect_out("to_done_in_launch", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0);
    expect_out("to_run8", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0);
    expect_out("to_ack", 1'b0, 1'b0, 1'b1, 1'b1, 16'd8);
    step(1'b0, 1'b0, 1'b0);
    expect_out("to_release", 1'b0, 1'b0, 1'b0, 1'b1, 16'd8);

    // Done on RUN cycle 8 beats the coincident timeout
    step(1'b0, 1'b1, 1'b0);
    expect_out("dt_filter_hold", 1'b0, 1'b0, 1'b0, 1'b1, 16'd8);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    expect_out("dt_launch_clears", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    expect_out("dt_done_wins", 1'b0, 1'b0, 1'b1, 1'b0, 16'd8);
    step(1'b0, 1'b0, 1'b0);
    expect_out("dt_release", 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);

    // Reset mid-RUN aborts silently; stale high request cannot relaunch
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    expect_out("rst_mid_run_busy", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b1, 1'b0);
    expect_out("rst_outputs_zero", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0);
      expect_out($sformatf("rst_no_relaunch%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    expect_out("rst_launch_after_low", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b0);
    expect_out("rst_single_pulse", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_launch_ctrl.md
Name: ddr_launch_ctrl

Overview:
Consumes the synchronized CPU request level (req_sync) in the clk_ddr domain and drives the CGRA launch. It glitch-filters the request, issues a one-cycle cgra_start pulse, and times the run until cgra_done or timeout. It returns a 4-phase done_ack level to the CPU side: done_ack rises at completion and falls after req_sync drops. Sits directly downstream of the CPU-to-DDR request synchronizer and upstream of the CGRA core.

Parameters:
FILTER_LEN, 2, number of consecutive high req_sync samples required before launch (>=1).
TIMEOUT_W, 16, width of run counter and run_cycles output.
TIMEOUT, 16'hFFFF, max RUN cycles before abort (>=1, < 2^TIMEOUT_W).

Ports:
clk_ddr  in  1  DDR-domain clock; all logic on posedge.
rst_ddr  in  1  reset, synchronous, active-high.
req_sync  in  1  synchronized CPU request level (4-phase req).
cgra_done  in  1  CGRA completion; sampled only in RUN.
cgra_start  out  1  one-cycle launch pulse to CGRA.
busy  out  1  high in LAUNCH and RUN.
done_ack  out  1  4-phase ack level to CPU domain.
timeout_err  out  1  last run ended by timeout.
run_cycles  out  TIMEOUT_W  cycles spent in RUN for last run.

Behaviour:
- All outputs registered. Reset: state=IDLE, armed=0, all outputs 0, counters 0. Reset mid-run aborts silently: no ack, no pulse.
- armed flag: set on any cycle req_sync=0 while in IDLE; cleared on entering FILTER. After reset a stale high req_sync cannot launch until it has been seen low once.
- IDLE: req_sync=1 & armed -> FILTER, filt_cnt=1.
- FILTER: req_sync=0 -> IDLE (glitch rejected; armed is set again by the IDLE rule). req_sync=1 & filt_cnt==FILTER_LEN -> LAUNCH; else filt_cnt++. With FILTER_LEN=1 the FILTER dwell is exactly one cycle.
- LAUNCH (1 cycle): cgra_start=1, busy=1. On entry clear run_cycles and timeout_err. Next state is RUN. cgra_done is ignored in this state.
- RUN: busy=1, run_cnt increments each cycle, starting at 1 on the first RUN cycle.
  - cgra_done=1 -> ACK, run_cycles=run_cnt, timeout_err=0.
  - else if run_cnt==TIMEOUT -> ACK, run_cycles=TIMEOUT, timeout_err=1.
  - cgra_done and timeout in the same cycle: done wins, err=0.
  - req_sync dropping during RUN is ignored; the run completes.
- ACK: done_ack=1, busy=0. req_sync=0 -> IDLE with done_ack=0 on the next cycle and armed=1.
- run_cycles and timeout_err hold their values until the next LAUNCH.
- cgra_start is never high for two consecutive cycles. There is at most one launch per req_sync high phase.
- Timing with FILTER_LEN=2: req_sync first high at edge t. FILTER at t+1; LAUNCH state, and cgra_start high, in the cycle after edge t+2.

Decomposition:
- Shared include/package ddr_launch_defs: state encodings (IDLE, FILTER, LAUNCH, RUN, ACK; 3-bit), default FILTER_LEN/TIMEOUT values.
- One natural sub-module, req_glitch_filter: FILTER_LEN consecutive-high counter with clear. The FSM, run counter and result registers stay in the top.

Test Plan:
- Reset with req_sync=1 held -> no cgra_start; drive req_sync 0 then 1 -> exactly one cgra_start pulse, 3 cycles after the rise (FILTER_LEN=2).
- req_sync high 1 cycle, then low -> FILTER aborts, no cgra_start, done_ack stays 0.
- Launch, cgra_done on 5th RUN cycle -> run_cycles=5, timeout_err=0, done_ack=1 until req_sync low; done_ack=0 the cycle after.
- TIMEOUT=8, cgra_done never asserted -> ACK after 8 RUN cycles, run_cycles=8, timeout_err=1.
- TIMEOUT=8, cgra_done on RUN cycle 8 -> run_cycles=8, timeout_err=0. cgra_done high during LAUNCH only -> ignored.
- rst_ddr asserted mid-RUN -> next cycle all outputs 0, state IDLE. req_sync still high -> no relaunch until it is seen low.
